// File: rtl/vscale_fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vscale_fetch_stage_pkg
// Description : Shared widths, defaults and sizing helpers for the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package vscale_fetch_stage_pkg;

    localparam int          DEF_XPR_LEN   = 32;
    localparam int          INST_WIDTH    = 32;
    localparam int          DEF_BUF_DEPTH = 3;
    localparam logic [31:0] DEF_RESET_PC  = 32'h200;

    // Pointer width for a circular buffer of the given depth (at least 1 bit).
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Width able to hold an occupancy count from 0 up to depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vscale_fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : vscale_fetch_stage_if
// Description : Instruction-memory port and DX-side instruction handshake.
// Revision    : 1.0 - initial release
// ============================================================================
interface vscale_fetch_stage_if
    import vscale_fetch_stage_pkg::*;
#(
    parameter int XPR_LEN = DEF_XPR_LEN
);
    logic                  imem_req_valid;
    logic                  imem_req_ready;
    logic [XPR_LEN-1:0]    imem_addr;
    logic                  imem_resp_valid;
    logic [INST_WIDTH-1:0] imem_resp_data;
    logic                  imem_resp_badmem;
    logic                  inst_valid;
    logic                  inst_ready;
    logic [INST_WIDTH-1:0] inst_data;
    logic [XPR_LEN-1:0]    inst_pc;
    logic                  inst_badmem;

    // Fetch-stage side.
    modport master (
        output imem_req_valid, imem_addr, inst_valid, inst_data, inst_pc, inst_badmem,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_badmem, inst_ready
    );

    // Memory / DX side.
    modport slave (
        input  imem_req_valid, imem_addr, inst_valid, inst_data, inst_pc, inst_badmem,
        output imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_badmem, inst_ready
    );
endinterface
`default_nettype wire

// File: rtl/vscale_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : vscale_fetch_fifo
// Description : Synchronous circular FIFO with clear, count and head output.
// Revision    : 1.0 - initial release
// ============================================================================
module vscale_fetch_fifo
    import vscale_fetch_stage_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = DEF_BUF_DEPTH,
    localparam int PTR_W = ptr_width(DEPTH),
    localparam int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign head = mem[rd_ptr];

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; clear empties the FIFO and overrides push/pop.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= bump(wr_ptr);
            if (pop)  rd_ptr <= bump(rd_ptr);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Callers guarantee space on push and data on pop.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset || clear)
        !(push && !pop && (count == CNT_W'(DEPTH))));
    a_no_underflow: assert property (@(posedge clk) disable iff (reset || clear)
        !(pop && (count == '0)));

endmodule
`default_nettype wire

// File: rtl/vscale_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : vscale_fetch_stage
// Description : Instruction fetch: owns PC_IF, issues credit-limited requests,
//               buffers in-order responses and hands them to DX; redirects
//               flush the buffer and discard in-flight responses.
// Revision    : 1.0 - initial release
// ============================================================================
module vscale_fetch_stage
    import vscale_fetch_stage_pkg::*;
#(
    parameter int                 XPR_LEN   = DEF_XPR_LEN,
    parameter int                 BUF_DEPTH = DEF_BUF_DEPTH,
    parameter logic [XPR_LEN-1:0] RESET_PC  = XPR_LEN'(DEF_RESET_PC)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [XPR_LEN-1:0] PC_PIF,
    input  logic               redirect,
    output logic [XPR_LEN-1:0] PC_IF,
    vscale_fetch_stage_if.master bus
);

    localparam int CNT_W  = cnt_width(BUF_DEPTH);
    localparam int RESP_W = INST_WIDTH + 1 + XPR_LEN;

    logic [CNT_W-1:0]   inflight;
    logic [CNT_W-1:0]   drop;
    logic [CNT_W-1:0]   buf_count;
    logic [CNT_W-1:0]   pc_count;
    logic [XPR_LEN-1:0] pc_head;
    logic [RESP_W-1:0]  resp_head;
    logic               credit;
    logic               accept;
    logic               resp_keep;
    logic               inst_pop;

    // Outstanding plus buffered never exceeds the buffer, so a kept response always fits.
    assign credit             = ({1'b0, inflight} + {1'b0, buf_count}) < (CNT_W + 1)'(BUF_DEPTH);
    assign bus.imem_req_valid = !reset && !redirect && credit;
    assign accept             = bus.imem_req_valid && bus.imem_req_ready;
    assign resp_keep          = bus.imem_resp_valid && !reset && !redirect && (drop == '0);
    assign inst_pop           = bus.inst_valid && bus.inst_ready;

    assign bus.imem_addr  = PC_IF;
    assign bus.inst_valid = (buf_count != '0);
    assign {bus.inst_data, bus.inst_badmem, bus.inst_pc} = resp_head;

    // PC_IF only moves on an accepted fetch or a redirect, so it holds during a stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            PC_IF <= RESET_PC;
        end else if (accept || redirect) begin
            PC_IF <= PC_PIF;
        end
    end

    // In-flight and discard bookkeeping; a response arriving with a redirect is already stale.
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight <= '0;
            drop     <= '0;
        end else begin
            inflight <= inflight + CNT_W'(accept) - CNT_W'(bus.imem_resp_valid);
            if (redirect) begin
                drop <= inflight - CNT_W'(bus.imem_resp_valid);
            end else if (bus.imem_resp_valid && (drop != '0)) begin
                drop <= drop - CNT_W'(1);
            end
        end
    end

    vscale_fetch_fifo #(
        .WIDTH (XPR_LEN),
        .DEPTH (BUF_DEPTH)
    ) u_pc_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (redirect),
        .push      (accept),
        .push_data (PC_IF),
        .pop       (resp_keep),
        .count     (pc_count),
        .head      (pc_head)
    );

    vscale_fetch_fifo #(
        .WIDTH (RESP_W),
        .DEPTH (BUF_DEPTH)
    ) u_resp_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (redirect),
        .push      (resp_keep),
        .push_data ({bus.imem_resp_data, bus.imem_resp_badmem, pc_head}),
        .pop       (inst_pop),
        .count     (buf_count),
        .head      (resp_head)
    );

    // Every live in-flight request has exactly one address waiting in the PC FIFO.
    a_pc_tracks_live: assert property (@(posedge clk) disable iff (reset)
        pc_count == (inflight - drop));
    a_no_spurious_resp: assert property (@(posedge clk) disable iff (reset)
        !(bus.imem_resp_valid && (inflight == '0)));

endmodule
`default_nettype wire

// File: tb/tb_vscale_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_vscale_fetch_stage
// Description : Randomised bench with a transaction-level model: the expected
//               instruction stream is every address fetched since the last
//               redirect/reset, delivered in order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vscale_fetch_stage;
    import vscale_fetch_stage_pkg::*;

    localparam int          DEPTH    = 3;
    localparam logic [31:0] RST_PC   = 32'h200;
    localparam logic [31:0] BAD_ADDR = 32'h208;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          live;
    } mem_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] PC_PIF;
    logic [31:0] PC_IF;

    vscale_fetch_stage_if #(.XPR_LEN(32)) bus ();

    vscale_fetch_stage #(
        .XPR_LEN   (32),
        .BUF_DEPTH (DEPTH),
        .RESET_PC  (RST_PC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .PC_PIF   (PC_PIF),
        .redirect (redirect),
        .PC_IF    (PC_IF),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] model_pc;
    logic [31:0] exp_q [$];
    mem_t        mem_q [$];
    int          nret;
    int          cyc;
    int          lat;
    int          total;
    int          bad;

    function automatic logic [31:0] inst_word(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'hC0DE_0013;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // One clock: drive inputs on the falling edge, check, then advance the model.
    task automatic step(input bit rst_i, input bit redir, input logic [31:0] tgt,
                        input bit dx_rdy, input bit mem_rdy, input bit junk);
        bit   exp_rv;
        bit   exp_iv;
        bit   resp;
        int   stale;
        mem_t e;
        @(negedge clk);
        reset    = rst_i;
        redirect = redir && !rst_i;
        if (redir)     PC_PIF = tgt;
        else if (junk) PC_PIF = 32'h200 + 32'($urandom_range(0, 63)) * 32'd4;
        else           PC_PIF = model_pc + 32'd4;
        bus.inst_ready     = dx_rdy;
        bus.imem_req_ready = mem_rdy;
        resp = !rst_i && (mem_q.size() > 0) && (mem_q[0].due == cyc);
        bus.imem_resp_valid = resp;
        if (resp) begin
            bus.imem_resp_data   = inst_word(mem_q[0].addr);
            bus.imem_resp_badmem = (mem_q[0].addr == BAD_ADDR);
        end else begin
            bus.imem_resp_data   = $urandom;
            bus.imem_resp_badmem = 1'($urandom_range(0, 1));
        end
        #1;
        exp_rv = !rst_i && !redirect && ((mem_q.size() + nret) < DEPTH);
        check_eq("req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
        if (rst_i) begin
            mem_q.delete();
            exp_q.delete();
            nret     = 0;
            model_pc = RST_PC;
        end else begin
            exp_iv = (nret > 0);
            check_eq("pc_if", PC_IF, model_pc);
            check_eq("inst_valid", 32'(bus.inst_valid), 32'(exp_iv));
            stale = 0;
            foreach (mem_q[i]) if (!mem_q[i].live) stale++;
            check_eq("drop", 32'(dut.drop), 32'(stale));
            if (exp_rv) check_eq("imem_addr", bus.imem_addr, model_pc);
            if (exp_iv && bus.inst_valid) begin
                check_eq("inst_pc", bus.inst_pc, exp_q[0]);
                check_eq("inst_data", bus.inst_data, inst_word(exp_q[0]));
                check_eq("inst_badmem", 32'(bus.inst_badmem), 32'(exp_q[0] == BAD_ADDR));
            end
            if (exp_iv && dx_rdy) begin
                void'(exp_q.pop_front());
                nret--;
            end
            if (resp) begin
                e = mem_q.pop_front();
                if (e.live && !redirect) nret++;
            end
            if (redirect) begin
                exp_q.delete();
                nret = 0;
                foreach (mem_q[i]) mem_q[i].live = 1'b0;
                model_pc = PC_PIF;
            end else if (exp_rv && mem_rdy) begin
                mem_q.push_back('{model_pc, cyc + lat, 1'b1});
                exp_q.push_back(model_pc);
                model_pc = PC_PIF;
            end
        end
        cyc++;
    endtask

    task automatic seq(input bit dx_rdy);
        step(1'b0, 1'b0, 32'h0, dx_rdy, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        reset = 1'b1; redirect = 1'b0; PC_PIF = '0;
        bus.inst_ready = 1'b0; bus.imem_req_ready = 1'b0; bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data = '0; bus.imem_resp_badmem = 1'b0;
        model_pc = RST_PC; nret = 0; cyc = 0; lat = 1; total = 0; bad = 0;

        // Streaming with a 1-cycle memory, including the faulting word at 0x208.
        lat = 1;
        do_reset(); do_reset();
        repeat (12) seq(1'b1);

        // DX stalled for 10 cycles, then released.
        do_reset();
        repeat (10) seq(1'b0);
        repeat (10) seq(1'b1);

        // Two requests in flight at 3-cycle latency, then redirect to 0x400.
        lat = 3;
        do_reset();
        repeat (2) seq(1'b1);
        step(1'b0, 1'b1, 32'h400, 1'b1, 1'b1, 1'b0);
        repeat (15) seq(1'b1);

        // Redirect in the same cycle a response arrives.
        lat = 2;
        do_reset();
        repeat (2) seq(1'b1);
        step(1'b0, 1'b1, 32'h600, 1'b1, 1'b1, 1'b0);
        repeat (10) seq(1'b1);

        // Reset with two in flight and one buffered, then restart.
        lat = 3;
        do_reset();
        repeat (4) seq(1'b0);
        do_reset();
        repeat (12) seq(1'b1);

        // Random back-pressure, redirects, PC-mux noise and memory latency.
        for (int s = 0; s < 30; s++) begin
            lat = $urandom_range(1, 4);
            do_reset();
            repeat (60) begin
                step(1'b0, $urandom_range(0, 15) == 0,
                     32'h200 + 32'($urandom_range(0, 63)) * 32'd4,
                     $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                     $urandom_range(0, 7) == 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
